// File: rtl/button_event_arbiter_pkg.sv
// Shared definitions for the button event arbiter.
// Holds the sizing constants, the button index codes and the round-robin
// search helper used by the top level.
package button_event_arbiter_pkg;

  localparam int NUM_BTN = 5;
  localparam int DEPTH   = 4;
  localparam int CODE_W  = 3;
  localparam int PTR_W   = 2;

  // FIFO occupancy value that means "full"; count carries full/empty.
  localparam logic [PTR_W:0] FIFO_FULL = (PTR_W+1)'(DEPTH);

  // Button index codes as seen on evt_code_out.
  localparam logic [CODE_W-1:0] BTN_CENTER = 3'd0;
  localparam logic [CODE_W-1:0] BTN_UP     = 3'd1;
  localparam logic [CODE_W-1:0] BTN_LEFT   = 3'd2;
  localparam logic [CODE_W-1:0] BTN_RIGHT  = 3'd3;
  localparam logic [CODE_W-1:0] BTN_DOWN   = 3'd4;

  // Round-robin pick: first set bit of req searching start, start+1, ...
  // modulo NUM_BTN. Returns {found, code}.
  function automatic logic [CODE_W:0] rr_pick(input logic [NUM_BTN-1:0] req,
                                              input logic [CODE_W-1:0]  start);
    logic              found;
    logic [CODE_W-1:0] code;
    logic [CODE_W:0]   sum;
    logic [CODE_W-1:0] idx;
    found = 1'b0;
    code  = '0;
    for (int k = 0; k < NUM_BTN; k++) begin
      sum = {1'b0, start} + (CODE_W+1)'(k);
      if (sum >= (CODE_W+1)'(NUM_BTN)) begin
        sum = sum - (CODE_W+1)'(NUM_BTN);
      end else begin
        sum = sum;
      end
      idx = sum[CODE_W-1:0];
      if (!found && req[idx]) begin
        found = 1'b1;
        code  = idx;
      end else begin
        found = found;
      end
    end
    return {found, code};
  endfunction

endpackage

// File: rtl/button_event_arbiter_if.sv
// Event channel between the debouncer/consumer side and the arbiter.
//   buttons_in       debounced 1-cycle press pulses
//   evt_ready_in     consumer accepts the head event
//   clr_overflow_in  clears the sticky overflow flag
//   evt_valid_out    head event valid
//   evt_code_out     head event button index
//   pending_out      captured-but-not-yet-queued flags
//   fifo_count_out   buffered event count
//   overflow_out     sticky dropped-event flag
// master: drives the inputs (debouncer/consumer); slave: the arbiter.
interface button_event_arbiter_if;
  import button_event_arbiter_pkg::*;

  logic [NUM_BTN-1:0] buttons_in;
  logic               evt_ready_in;
  logic               clr_overflow_in;
  logic               evt_valid_out;
  logic [CODE_W-1:0]  evt_code_out;
  logic [NUM_BTN-1:0] pending_out;
  logic [PTR_W:0]     fifo_count_out;
  logic               overflow_out;

  modport master (
    output buttons_in, evt_ready_in, clr_overflow_in,
    input  evt_valid_out, evt_code_out, pending_out, fifo_count_out, overflow_out
  );

  modport slave (
    input  buttons_in, evt_ready_in, clr_overflow_in,
    output evt_valid_out, evt_code_out, pending_out, fifo_count_out, overflow_out
  );
endinterface

// File: rtl/button_event_fifo.sv
// Synchronous DEPTH x CODE_W event FIFO.
//   clk_i, rst_ni   clock, async active-low reset
//   push_i, data_i  write request and code (ignored when full)
//   pop_i           read request (ignored when empty)
//   count_o         entries held; head_o is the oldest entry, 0 when empty
module button_event_fifo
  import button_event_arbiter_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [CODE_W-1:0] data_i,
  input  logic              pop_i,
  output logic [PTR_W:0]    count_o,
  output logic [CODE_W-1:0] head_o
);

  logic [CODE_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_q, wr_d;
  logic [PTR_W-1:0]  rd_q, rd_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              push_ok_s, pop_ok_s;

  // Qualify requests and compute pointer/count updates; pointers wrap naturally.
  always_comb begin
    push_ok_s = push_i & (count_q != FIFO_FULL);
    pop_ok_s  = pop_i & (count_q != '0);
    wr_d      = wr_q;
    rd_d      = rd_q;
    count_d   = count_q;
    if (push_ok_s) begin
      wr_d = wr_q + PTR_W'(1);
    end else begin
      wr_d = wr_q;
    end
    if (pop_ok_s) begin
      rd_d = rd_q + PTR_W'(1);
    end else begin
      rd_d = rd_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_ok_s) begin
        mem_q[wr_q] <= data_i;
      end
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign head_o  = (count_q != '0) ? mem_q[rd_q] : '0;

endmodule

// File: rtl/button_event_arbiter.sv
// Button event arbiter: captures debounced press pulses, grants one pending
// button per cycle in round-robin order into an event FIFO and presents the
// oldest event on a valid/ready channel.
//   clock_in   system clock (rising edge)
//   reset_in   async active-low reset, discards all pending/buffered events
//   bus        event channel (slave side), see button_event_arbiter_if
module button_event_arbiter
  import button_event_arbiter_pkg::*;
(
  input  logic                        clock_in,
  input  logic                        reset_in,
  button_event_arbiter_if.slave       bus
);

  logic [NUM_BTN-1:0] pending_q, pending_d;
  logic [CODE_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic               overflow_q, overflow_d;

  logic [CODE_W:0]    pick_s;
  logic               grant_valid_s;
  logic [CODE_W-1:0]  grant_code_s;
  logic [NUM_BTN-1:0] grant_vec_s;
  logic               drop_s;
  logic               pop_s;
  logic [PTR_W:0]     count_s;
  logic [CODE_W-1:0]  head_s;

  // Arbitration, capture, drop detection and round-robin pointer update.
  always_comb begin
    pick_s        = rr_pick(pending_q, rr_ptr_q);
    // A full FIFO blocks granting, so pending bits simply hold.
    grant_valid_s = pick_s[CODE_W] & (count_s != FIFO_FULL);
    grant_code_s  = pick_s[CODE_W-1:0];
    grant_vec_s   = '0;
    if (grant_valid_s) begin
      grant_vec_s[grant_code_s] = 1'b1;
    end else begin
      grant_vec_s = '0;
    end
    pending_d = (pending_q & ~grant_vec_s) | bus.buttons_in;
    // A press on a bit being granted this cycle re-arms it rather than dropping.
    drop_s    = |(bus.buttons_in & pending_q & ~grant_vec_s);
    if (drop_s) begin
      overflow_d = 1'b1;
    end else if (bus.clr_overflow_in) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
    if (!grant_valid_s) begin
      rr_ptr_d = rr_ptr_q;
    end else if (grant_code_s == CODE_W'(NUM_BTN - 1)) begin
      rr_ptr_d = '0;
    end else begin
      rr_ptr_d = grant_code_s + CODE_W'(1);
    end
    pop_s = (count_s != '0) & bus.evt_ready_in;
  end

  // Pending flags, round-robin pointer and sticky overflow.
  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      pending_q  <= '0;
      rr_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      rr_ptr_q   <= rr_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  button_event_fifo u_fifo (
    .clk_i   (clock_in),
    .rst_ni  (reset_in),
    .push_i  (grant_valid_s),
    .data_i  (grant_code_s),
    .pop_i   (pop_s),
    .count_o (count_s),
    .head_o  (head_s)
  );

  assign bus.evt_valid_out  = (count_s != '0);
  assign bus.evt_code_out   = head_s;
  assign bus.pending_out    = pending_q;
  assign bus.fifo_count_out = count_s;
  assign bus.overflow_out   = overflow_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed testbench for button_event_arbiter with hand-computed expectations.
module tb_button_event_arbiter;

  logic clock_in = 1'b0;
  logic reset_in = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  button_event_arbiter_if bif ();

  button_event_arbiter dut (
    .clock_in (clock_in),
    .reset_in (reset_in),
    .bus      (bif.slave)
  );

  // Free-running clock, period 10.
  initial forever #5 clock_in = ~clock_in;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock_in);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset_in = 1'b0;
    bif.buttons_in = 5'b00000;
    bif.evt_ready_in = 1'b0;
    bif.clr_overflow_in = 1'b0;
    ticks(2);
    reset_in = 1'b1;
    tick();
  endtask

  // Expect head event code then pop it (ready must already be 1).
  task automatic expect_pop(input string tag, input logic [2:0] code);
    check_eq({tag, "_valid"}, 32'(bif.evt_valid_out), 32'd1);
    check_eq({tag, "_code"}, 32'(bif.evt_code_out), 32'(code));
    tick();
  endtask

  initial begin
    bif.buttons_in = 5'b00000;
    bif.evt_ready_in = 1'b0;
    bif.clr_overflow_in = 1'b0;

    // Reset state.
    do_reset();
    check_eq("rst_valid", 32'(bif.evt_valid_out), 32'd0);
    check_eq("rst_code", 32'(bif.evt_code_out), 32'd0);
    check_eq("rst_pending", 32'(bif.pending_out), 32'd0);
    check_eq("rst_count", 32'(bif.fifo_count_out), 32'd0);
    check_eq("rst_ovf", 32'(bif.overflow_out), 32'd0);

    // 1. Single press, latency N+2, one-cycle valid.
    bif.evt_ready_in = 1'b1;
    bif.buttons_in = 5'b00100;
    tick();
    bif.buttons_in = 5'b00000;
    check_eq("t1_pend", 32'(bif.pending_out), 32'b00100);
    check_eq("t1_nvalid", 32'(bif.evt_valid_out), 32'd0);
    tick();
    check_eq("t1_count1", 32'(bif.fifo_count_out), 32'd1);
    check_eq("t1_pend0", 32'(bif.pending_out), 32'd0);
    expect_pop("t1", 3'd2);
    check_eq("t1_done_valid", 32'(bif.evt_valid_out), 32'd0);
    check_eq("t1_done_count", 32'(bif.fifo_count_out), 32'd0);

    // 2. All five at once with ready low: fill, hold, then drain in order.
    do_reset();
    bif.buttons_in = 5'b11111;
    tick();
    bif.buttons_in = 5'b00000;
    ticks(4);
    check_eq("t2_full", 32'(bif.fifo_count_out), 32'd4);
    check_eq("t2_pend", 32'(bif.pending_out), 32'b10000);
    tick();
    check_eq("t2_hold_count", 32'(bif.fifo_count_out), 32'd4);
    check_eq("t2_hold_pend", 32'(bif.pending_out), 32'b10000);
    bif.evt_ready_in = 1'b1;
    expect_pop("t2_0", 3'd0);
    check_eq("t2_nobypass", 32'(bif.fifo_count_out), 32'd3);
    expect_pop("t2_1", 3'd1);
    check_eq("t2_pushpop", 32'(bif.fifo_count_out), 32'd3);
    expect_pop("t2_2", 3'd2);
    expect_pop("t2_3", 3'd3);
    expect_pop("t2_4", 3'd4);
    check_eq("t2_empty", 32'(bif.evt_valid_out), 32'd0);

    // 3. Fairness: rr_ptr=3 after grant of 2, then buttons 3 and 0.
    do_reset();
    bif.evt_ready_in = 1'b1;
    bif.buttons_in = 5'b00100;
    tick();
    bif.buttons_in = 5'b00000;
    ticks(3);
    bif.evt_ready_in = 1'b0;
    bif.buttons_in = 5'b01001;
    tick();
    bif.buttons_in = 5'b00000;
    ticks(2);
    check_eq("t3_count", 32'(bif.fifo_count_out), 32'd2);
    bif.evt_ready_in = 1'b1;
    expect_pop("t3_a", 3'd3);
    expect_pop("t3_b", 3'd0);
    // rr_ptr should now be 1: buttons 0 and 1 together must yield 1 first.
    bif.evt_ready_in = 1'b0;
    bif.buttons_in = 5'b00011;
    tick();
    bif.buttons_in = 5'b00000;
    ticks(2);
    bif.evt_ready_in = 1'b1;
    expect_pop("t3_c", 3'd1);
    expect_pop("t3_d", 3'd0);
    check_eq("t3_empty", 32'(bif.evt_valid_out), 32'd0);

    // 4. Overflow: full FIFO, button 1 pressed twice.
    do_reset();
    bif.buttons_in = 5'b11101;
    tick();
    bif.buttons_in = 5'b00000;
    ticks(4);
    check_eq("t4_full", 32'(bif.fifo_count_out), 32'd4);
    bif.buttons_in = 5'b00010;
    tick();
    check_eq("t4_no_ovf", 32'(bif.overflow_out), 32'd0);
    tick();
    bif.buttons_in = 5'b00000;
    check_eq("t4_ovf", 32'(bif.overflow_out), 32'd1);
    check_eq("t4_pend", 32'(bif.pending_out), 32'b00010);
    bif.evt_ready_in = 1'b1;
    expect_pop("t4_0", 3'd0);
    expect_pop("t4_2", 3'd2);
    expect_pop("t4_3", 3'd3);
    expect_pop("t4_4", 3'd4);
    expect_pop("t4_1", 3'd1);
    check_eq("t4_single1", 32'(bif.evt_valid_out), 32'd0);
    check_eq("t4_sticky", 32'(bif.overflow_out), 32'd1);
    bif.clr_overflow_in = 1'b1;
    tick();
    bif.clr_overflow_in = 1'b0;
    check_eq("t4_clr", 32'(bif.overflow_out), 32'd0);

    // 5. Press coinciding with its own grant is not a drop.
    do_reset();
    bif.buttons_in = 5'b10000;
    tick();
    tick();
    bif.buttons_in = 5'b00000;
    check_eq("t5_pend", 32'(bif.pending_out), 32'b10000);
    check_eq("t5_ovf", 32'(bif.overflow_out), 32'd0);
    check_eq("t5_count1", 32'(bif.fifo_count_out), 32'd1);
    tick();
    check_eq("t5_count2", 32'(bif.fifo_count_out), 32'd2);
    bif.evt_ready_in = 1'b1;
    expect_pop("t5_a", 3'd4);
    expect_pop("t5_b", 3'd4);
    check_eq("t5_empty", 32'(bif.evt_valid_out), 32'd0);
    check_eq("t5_ovf_end", 32'(bif.overflow_out), 32'd0);

    // 6. Asynchronous reset mid-stream.
    do_reset();
    bif.buttons_in = 5'b01111;
    tick();
    bif.buttons_in = 5'b00000;
    ticks(3);
    check_eq("t6_count", 32'(bif.fifo_count_out), 32'd3);
    check_eq("t6_pend", 32'(bif.pending_out), 32'b01000);
    #2;
    reset_in = 1'b0;
    #1;
    check_eq("t6_async_valid", 32'(bif.evt_valid_out), 32'd0);
    check_eq("t6_async_code", 32'(bif.evt_code_out), 32'd0);
    check_eq("t6_async_count", 32'(bif.fifo_count_out), 32'd0);
    check_eq("t6_async_pend", 32'(bif.pending_out), 32'd0);
    tick();
    reset_in = 1'b1;
    bif.evt_ready_in = 1'b1;
    ticks(3);
    check_eq("t6_post_valid", 32'(bif.evt_valid_out), 32'd0);
    check_eq("t6_post_count", 32'(bif.fifo_count_out), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
